// File: rtl/fadd_arbiter.sv
// fadd_arbiter: lets two requesters share one pipelined single-precision adder.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/reqN_ready    operation handshake for requester N (N = 0, 1)
//   reqN_x1, reqN_x2         IEEE single operands a and b
//   reqN_sub                 1: a-b, 0: a+b (implemented by flipping b's sign)
//   resN_valid/resN_ready    result handshake for requester N
//   resN_y                   result (head of requester N's result FIFO)
//
// The adder cannot stall, so each requester owns a result FIFO.
// A per-requester credit counter covers both in-flight operations and FIFO
// entries. Issue is refused once the counter reaches DEPTH, which guarantees
// that every adder result has a FIFO slot when it emerges.

// fadd: two-stage pipelined IEEE single adder (round to nearest even).
// If x2 has a zero exponent the result is x1; otherwise, if x1 has a zero
// exponent, the result is x2. Subnormal results flush to signed zero.
// Overflow saturates to infinity. There is no NaN handling.
module fadd (
    input  logic        clk,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);
    logic        byp_q, byp_d;
    logic [31:0] byp_val_q, byp_val_d;
    logic        sgn_q, sgn_d;
    logic [7:0]  exp_q, exp_d;
    logic        eff_sub_q, eff_sub_d;
    logic [26:0] mb_q, mb_d, ms_q, ms_d;
    logic [31:0] y_q, y_d;
    logic        a_big_s;
    logic [27:0] sum_s;
    logic [26:0] norm_s;
    logic [4:0]  lz_s;
    logic [9:0]  exp_s;
    logic        rnd_s;
    logic [24:0] mant_s;

    // Right shift that ORs the bits shifted out into bit 0 (the sticky bit).
    function automatic logic [26:0] shr_sticky(input logic [26:0] v, input logic [7:0] d);
        logic [26:0] r;
        logic        st;
        if (d >= 8'd27) begin
            r  = 27'd0;
            st = |v;
        end else begin
            r  = v >> d;
            st = |(v & ~({27{1'b1}} << d));
        end
        return {r[26:1], r[0] | st};
    endfunction

    // Count leading zeros of a 27-bit value.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Stage 1: detect the bypass cases, order the operands by magnitude, and align the smaller one.
    always_comb begin
        byp_d     = 1'b0;
        byp_val_d = 32'd0;
        if (x2[30:23] == 8'd0) begin
            byp_d     = 1'b1;
            byp_val_d = x1;
        end else if (x1[30:23] == 8'd0) begin
            byp_d     = 1'b1;
            byp_val_d = x2;
        end else begin
            byp_d     = 1'b0;
            byp_val_d = 32'd0;
        end
        a_big_s   = (x1[30:0] >= x2[30:0]);
        eff_sub_d = x1[31] ^ x2[31];
        if (a_big_s) begin
            sgn_d = x1[31];
            exp_d = x1[30:23];
            mb_d  = {1'b1, x1[22:0], 3'b000};
            ms_d  = shr_sticky({1'b1, x2[22:0], 3'b000}, x1[30:23] - x2[30:23]);
        end else begin
            sgn_d = x2[31];
            exp_d = x2[30:23];
            mb_d  = {1'b1, x2[22:0], 3'b000};
            ms_d  = shr_sticky({1'b1, x1[22:0], 3'b000}, x2[30:23] - x1[30:23]);
        end
    end

    // Stage 2: add or subtract, normalise, round, and pack the result.
    always_comb begin
        sum_s = eff_sub_q ? ({1'b0, mb_q} - {1'b0, ms_q}) : ({1'b0, mb_q} + {1'b0, ms_q});
        lz_s  = lzc27(sum_s[26:0]);
        if (sum_s[27]) begin
            norm_s = {sum_s[27:2], sum_s[1] | sum_s[0]};
            exp_s  = {2'b00, exp_q} + 10'd1;
        end else begin
            norm_s = sum_s[26:0] << lz_s;
            exp_s  = {2'b00, exp_q} - {5'd0, lz_s};
        end
        // Round to nearest, ties to even (guard, round and sticky are bits 2..0).
        rnd_s  = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_s = {1'b0, norm_s[26:3]} + {24'd0, rnd_s};
        if (mant_s[24]) begin
            exp_s = exp_s + 10'd1;
        end else begin
            exp_s = exp_s;
        end
        // A negative exponent wraps into bit 9.
        if (byp_q) begin
            y_d = byp_val_q;
        end else if (sum_s == 28'd0) begin
            y_d = 32'd0;
        end else if (exp_s[9] || (exp_s == 10'd0)) begin
            y_d = {sgn_q, 31'd0};
        end else if (exp_s >= 10'd255) begin
            y_d = {sgn_q, 8'hFF, 23'd0};
        end else begin
            y_d = {sgn_q, exp_s[7:0], mant_s[22:0]};
        end
    end

    // Pipeline registers. The datapath is not reset because valid tags are tracked outside.
    always_ff @(posedge clk) begin
        byp_q     <= byp_d;
        byp_val_q <= byp_val_d;
        sgn_q     <= sgn_d;
        exp_q     <= exp_d;
        eff_sub_q <= eff_sub_d;
        mb_q      <= mb_d;
        ms_q      <= ms_d;
        y_q       <= y_d;
    end

    assign y = y_q;
endmodule

// fadd_arb_fifo: registered first-word-fall-through result FIFO.
// Push and pop may happen together in the same cycle, including when the FIFO is full.
module fadd_arb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic        empty_o,
    output logic [31:0] head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;

    // Pointer update. The extra MSB tells full apart from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PTR_ONE;
            if (pop_i)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Entry storage. Entries are not reset; the pointers alone mark which ones are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[AW-1:0]];
endmodule

module fadd_arbiter #(
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    input  logic        req0_sub,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic [31:0] res0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,
    input  logic        req1_sub,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [31:0] res1_y
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic           prio_q, prio_d;
    logic [LAT-1:0] tag_v_q, tag_id_q;
    logic [1:0]     valid_s, elig_s, cand_s, grant_s, pop_s, push_s, empty_s, res_valid_s;
    logic           gid_s, sub_s;
    logic [31:0]    fx1_s, fx2_raw_s, fx2_s, fy_s, head0_s, head1_s;

    assign valid_s = {req1_valid, req0_valid};
    assign elig_s  = {(cnt1_q < DEPTH_C), (cnt0_q < DEPTH_C)};

    // Round-robin grant among the valid requesters that have credit. Nothing is granted during reset.
    always_comb begin
        cand_s = valid_s & elig_s;
        if (rst) begin
            grant_s = 2'b00;
        end else if (cand_s == 2'b11) begin
            grant_s = prio_q ? 2'b10 : 2'b01;
        end else begin
            grant_s = cand_s;
        end
    end

    // After a grant, priority passes to the other requester.
    always_comb begin
        case (grant_s)
            2'b01:   prio_d = 1'b1;
            2'b10:   prio_d = 1'b0;
            default: prio_d = prio_q;
        endcase
    end

    // Operand mux. Subtraction flips the sign of the second operand. Data is don't-care on a bubble.
    always_comb begin
        gid_s     = grant_s[1];
        fx1_s     = gid_s ? req1_x1 : req0_x1;
        fx2_raw_s = gid_s ? req1_x2 : req0_x2;
        sub_s     = gid_s ? req1_sub : req0_sub;
        fx2_s     = {fx2_raw_s[31] ^ sub_s, fx2_raw_s[30:0]};
    end

    fadd u_fadd (
        .clk (clk),
        .x1  (fx1_s),
        .x2  (fx2_s),
        .y   (fy_s)
    );

    // Tag pipe that runs alongside the adder; a bubble carries valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            tag_v_q  <= {tag_v_q[LAT-2:0], |grant_s};
            tag_id_q <= {tag_id_q[LAT-2:0], grant_s[1]};
        end
    end

    assign push_s      = {tag_v_q[LAT-1] & tag_id_q[LAT-1], tag_v_q[LAT-1] & ~tag_id_q[LAT-1]};
    assign res_valid_s = ~empty_s & {2{~rst}};
    assign pop_s       = res_valid_s & {res1_ready, res0_ready};

    fadd_arb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s[0]),
        .push_data_i (fy_s),
        .pop_i       (pop_s[0]),
        .empty_o     (empty_s[0]),
        .head_o      (head0_s)
    );

    fadd_arb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s[1]),
        .push_data_i (fy_s),
        .pop_i       (pop_s[1]),
        .empty_o     (empty_s[1]),
        .head_o      (head1_s)
    );

    // Credit next state: +1 on grant, -1 on pop; both together leave it unchanged.
    always_comb begin
        case ({grant_s[0], pop_s[0]})
            2'b10:   cnt0_d = cnt0_q + CNT_ONE;
            2'b01:   cnt0_d = cnt0_q - CNT_ONE;
            default: cnt0_d = cnt0_q;
        endcase
        case ({grant_s[1], pop_s[1]})
            2'b10:   cnt1_d = cnt1_q + CNT_ONE;
            2'b01:   cnt1_d = cnt1_q - CNT_ONE;
            default: cnt1_d = cnt1_q;
        endcase
    end

    // Credit counters and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            prio_q <= 1'b0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            prio_q <= prio_d;
        end
    end

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];
    assign res0_valid = res_valid_s[0];
    assign res1_valid = res_valid_s[1];
    assign res0_y     = head0_s;
    assign res1_y     = head1_s;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter: reset, add/sub, contention, back-pressure,
// push+pop at full credit, and reset while operations are in flight.
module tb_fadd_arbiter;
    localparam logic [31:0] HALF = 32'h3F000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub, res0_valid, res0_ready;
    logic        req1_valid, req1_ready, req1_sub, res1_valid, res1_ready;
    logic [31:0] req0_x1, req0_x2, res0_y, req1_x1, req1_x2, res1_y;
    int          checks = 0;
    int          failures = 0;

    fadd_arbiter #(.DEPTH(4), .LAT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x1    (req0_x1),
        .req0_x2    (req0_x2),
        .req0_sub   (req0_sub),
        .res0_valid (res0_valid),
        .res0_ready (res0_ready),
        .res0_y     (res0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x1    (req1_x1),
        .req1_x2    (req1_x2),
        .req1_sub   (req1_sub),
        .res1_valid (res1_valid),
        .res1_ready (res1_ready),
        .res1_y     (res1_y)
    );

    always #5 clk = ~clk;

    // Operand k (1.0 .. 8.0) and the sum k + 0.5.
    function automatic logic [31:0] c_in(input int k);
        case (k % 8)
            0: return 32'h3F800000;
            1: return 32'h40000000;
            2: return 32'h40400000;
            3: return 32'h40800000;
            4: return 32'h40A00000;
            5: return 32'h40C00000;
            6: return 32'h40E00000;
            default: return 32'h41000000;
        endcase
    endfunction

    function automatic logic [31:0] c_out(input int k);
        case (k % 8)
            0: return 32'h3FC00000;
            1: return 32'h40200000;
            2: return 32'h40600000;
            3: return 32'h40900000;
            4: return 32'h40B00000;
            5: return 32'h40D00000;
            6: return 32'h40F00000;
            default: return 32'h41080000;
        endcase
    endfunction

    // Requester 1 table: 1.5+0.5, 5.0+0.5, 2.0-0.5, 4.0-0.5.
    function automatic logic [31:0] t1_x1(input int k);
        case (k % 4)
            0: return 32'h3FC00000;
            1: return 32'h40A00000;
            2: return 32'h40000000;
            default: return 32'h40800000;
        endcase
    endfunction

    function automatic logic t1_sub(input int k);
        return (k % 4) >= 2;
    endfunction

    function automatic logic [31:0] t1_out(input int k);
        case (k % 4)
            0: return 32'h40000000;
            1: return 32'h40B00000;
            2: return 32'h3FC00000;
            default: return 32'h40600000;
        endcase
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        req0_valid = 1'b0; req0_x1 = 32'd0; req0_x2 = 32'd0; req0_sub = 1'b0; res0_ready = 1'b0;
        req1_valid = 1'b0; req1_x1 = 32'd0; req1_x2 = 32'd0; req1_sub = 1'b0; res1_ready = 1'b0;
    endtask

    // Leaves the bench at the start of the first cycle with rst low (cycle 0).
    task automatic apply_reset;
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        req0_valid = 1'b1; req1_valid = 1'b1; res0_ready = 1'b1; res1_ready = 1'b1;
        req0_x1 = c_in(0); req0_x2 = HALF; req1_x1 = c_in(1); req1_x2 = HALF;
        rst = 1'b1;
        next_cycle();
        mid();
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
        checks++; if (res0_valid !== 1'b0) begin failures++; $display("FAIL reset_res0_valid got=%b exp=0", res0_valid); end
        checks++; if (res1_valid !== 1'b0) begin failures++; $display("FAIL reset_res1_valid got=%b exp=0", res1_valid); end
        checks++; if (dut.cnt0_q !== 3'd0) begin failures++; $display("FAIL reset_cnt0 got=%0d exp=0", dut.cnt0_q); end
        checks++; if (dut.prio_q !== 1'b0) begin failures++; $display("FAIL reset_prio got=%b exp=0", dut.prio_q); end
        next_cycle();
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_basic_add;
        apply_reset();
        req0_valid = 1'b1; req0_x1 = 32'h3F800000; req0_x2 = 32'h40000000; req0_sub = 1'b0;
        mid();
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL add_accept got=%b exp=1", req0_ready); end
        next_cycle();
        req0_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            mid();
            checks++; if (res0_valid !== (c == 3)) begin failures++; $display("FAIL add_res0_valid cyc=%0d got=%b exp=%b", c, res0_valid, (c == 3)); end
            checks++; if (res1_valid !== 1'b0) begin failures++; $display("FAIL add_res1_valid cyc=%0d got=%b exp=0", c, res1_valid); end
            if (c == 3) begin
                checks++; if (res0_y !== 32'h40400000) begin failures++; $display("FAIL add_res0_y got=%h exp=40400000", res0_y); end
                res0_ready = 1'b1;
            end
            next_cycle();
        end
        res0_ready = 1'b0;
        mid();
        checks++; if (res0_valid !== 1'b0) begin failures++; $display("FAIL add_after_pop got=%b exp=0", res0_valid); end
        next_cycle();
    endtask

    task automatic test_subtract;
        apply_reset();
        req1_valid = 1'b1; req1_x1 = 32'h40400000; req1_x2 = 32'h3F800000; req1_sub = 1'b1;
        mid();
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL sub_accept got=%b exp=1", req1_ready); end
        next_cycle();
        req1_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            mid();
            checks++; if (res1_valid !== (c == 3)) begin failures++; $display("FAIL sub_res1_valid cyc=%0d got=%b exp=%b", c, res1_valid, (c == 3)); end
            checks++; if (res0_valid !== 1'b0) begin failures++; $display("FAIL sub_res0_valid cyc=%0d got=%b exp=0", c, res0_valid); end
            if (c == 3) begin
                checks++; if (res1_y !== 32'h40000000) begin failures++; $display("FAIL sub_res1_y got=%h exp=40000000", res1_y); end
            end
            next_cycle();
        end
    endtask

    task automatic test_contention;
        int n0, n1, r0, r1;
        apply_reset();
        n0 = 0; n1 = 0; r0 = 0; r1 = 0;
        res0_ready = 1'b1; res1_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            req0_valid = (k < 8); req1_valid = (k < 8);
            req0_x1 = c_in(n0); req0_x2 = HALF; req0_sub = 1'b0;
            req1_x1 = t1_x1(n1); req1_x2 = HALF; req1_sub = t1_sub(n1);
            mid();
            if (k < 8) begin
                checks++; if (req0_ready !== (k % 2 == 0)) begin failures++; $display("FAIL cont_grant0 cyc=%0d got=%b exp=%b", k, req0_ready, (k % 2 == 0)); end
                checks++; if (req1_ready !== (k % 2 == 1)) begin failures++; $display("FAIL cont_grant1 cyc=%0d got=%b exp=%b", k, req1_ready, (k % 2 == 1)); end
            end
            if (req0_ready) n0++;
            if (req1_ready) n1++;
            if (res0_valid) begin
                checks++; if (res0_y !== c_out(r0)) begin failures++; $display("FAIL cont_res0_y idx=%0d got=%h exp=%h", r0, res0_y, c_out(r0)); end
                r0++;
            end
            if (res1_valid) begin
                checks++; if (res1_y !== t1_out(r1)) begin failures++; $display("FAIL cont_res1_y idx=%0d got=%h exp=%h", r1, res1_y, t1_out(r1)); end
                r1++;
            end
            next_cycle();
        end
        checks++; if (r0 != 4 || r1 != 4) begin failures++; $display("FAIL cont_result_count got=%0d/%0d exp=4/4", r0, r1); end
    endtask

    task automatic test_backpressure;
        int  hs0, n0;
        logic e0, e1;
        apply_reset();
        hs0 = 0; n0 = 0;
        res0_ready = 1'b0; res1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_x2 = HALF; req1_x1 = c_in(0); req1_x2 = HALF;
        for (int k = 0; k < 12; k++) begin
            req0_x1 = c_in(n0);
            mid();
            e0 = (k < 8) && (k % 2 == 0);
            e1 = (k >= 7) || (k % 2 == 1);
            checks++; if (req0_ready !== e0) begin failures++; $display("FAIL bp_ready0 cyc=%0d got=%b exp=%b", k, req0_ready, e0); end
            checks++; if (req1_ready !== e1) begin failures++; $display("FAIL bp_ready1 cyc=%0d got=%b exp=%b", k, req1_ready, e1); end
            if (req0_ready) begin hs0++; n0++; end
            next_cycle();
        end
        checks++; if (hs0 != 4) begin failures++; $display("FAIL bp_handshakes got=%0d exp=4", hs0); end
        req0_x1 = c_in(n0);
        res0_ready = 1'b1;
        mid();
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL bp_pop_cycle_ready0 got=%b exp=0", req0_ready); end
        checks++; if (res0_valid !== 1'b1 || res0_y !== c_out(0)) begin failures++; $display("FAIL bp_pop_data got=%b/%h exp=1/%h", res0_valid, res0_y, c_out(0)); end
        next_cycle();
        res0_ready = 1'b0;
        mid();
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL bp_regrant0 got=%b exp=1", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL bp_regrant1 got=%b exp=0", req1_ready); end
        checks++; if (res0_y !== c_out(1)) begin failures++; $display("FAIL bp_next_head got=%h exp=%h", res0_y, c_out(1)); end
        next_cycle();
        mid();
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin failures++; $display("FAIL bp_refull got=%b%b exp=01", req0_ready, req1_ready); end
        next_cycle();
    endtask

    task automatic test_full_push_pop;
        int   n0, r0;
        logic e0;
        apply_reset();
        n0 = 0; r0 = 0;
        req0_x2 = HALF;
        for (int k = 0; k < 20; k++) begin
            res0_ready = (k >= 8);
            req0_valid = (k < 16);
            req0_x1 = c_in(n0);
            mid();
            e0 = (k < 4) || (k >= 9 && k < 16);
            checks++; if (req0_ready !== e0) begin failures++; $display("FAIL full_ready0 cyc=%0d got=%b exp=%b", k, req0_ready, e0); end
            if (k == 8) begin
                checks++; if (dut.cnt0_q !== 3'd4) begin failures++; $display("FAIL full_cnt0_full got=%0d exp=4", dut.cnt0_q); end
            end
            if (k >= 10 && k < 16) begin
                checks++; if (dut.cnt0_q !== 3'd3) begin failures++; $display("FAIL full_cnt0_steady cyc=%0d got=%0d exp=3", k, dut.cnt0_q); end
            end
            if (k == 19) begin
                checks++; if (dut.cnt0_q !== 3'd0) begin failures++; $display("FAIL full_cnt0_drain got=%0d exp=0", dut.cnt0_q); end
            end
            if (req0_ready) n0++;
            if (res0_valid && res0_ready) begin
                checks++; if (res0_y !== c_out(r0)) begin failures++; $display("FAIL full_order idx=%0d got=%h exp=%h", r0, res0_y, c_out(r0)); end
                r0++;
            end
            next_cycle();
        end
        checks++; if (n0 != 11 || r0 != 11) begin failures++; $display("FAIL full_counts got=%0d/%0d exp=11/11", n0, r0); end
    endtask

    task automatic test_reset_midflight;
        int got;
        apply_reset();
        res0_ready = 1'b1; req0_x2 = HALF;
        for (int k = 0; k < 2; k++) begin
            req0_valid = 1'b1; req0_x1 = c_in(k);
            mid();
            checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rmf_accept cyc=%0d got=%b exp=1", k, req0_ready); end
            next_cycle();
        end
        req0_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mid();
            checks++; if (res0_valid !== 1'b0) begin failures++; $display("FAIL rmf_stale_result cyc=%0d got=%b exp=0", k, res0_valid); end
            if (k == 0) begin
                checks++; if (dut.cnt0_q !== 3'd0) begin failures++; $display("FAIL rmf_cnt0 got=%0d exp=0", dut.cnt0_q); end
            end
            next_cycle();
        end
        req0_valid = 1'b1; req0_x1 = c_in(2);
        mid();
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rmf_new_accept got=%b exp=1", req0_ready); end
        next_cycle();
        req0_valid = 1'b0;
        got = 0;
        for (int j = 1; j <= 5; j++) begin
            mid();
            checks++; if (res0_valid !== (j == 3)) begin failures++; $display("FAIL rmf_new_valid cyc=%0d got=%b exp=%b", j, res0_valid, (j == 3)); end
            if (res0_valid) begin
                checks++; if (res0_y !== c_out(2)) begin failures++; $display("FAIL rmf_new_y got=%h exp=%h", res0_y, c_out(2)); end
                got++;
            end
            next_cycle();
        end
        checks++; if (got != 1) begin failures++; $display("FAIL rmf_result_count got=%0d exp=1", got); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        test_reset();
        test_basic_add();
        test_subtract();
        test_contention();
        test_backpressure();
        test_full_push_pop();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fadd_arbiter.md
Name: fadd_arbiter

Overview:
- Shares one pipelined `fadd` instance between two requesters (e.g. the FPU issue port and the `fsqrt`/`fdiv` helper sequencer). Each side has its own valid/ready request and response channel.
- Round-robin issue, at most one operation per cycle into `fadd`. Subtraction is done by flipping the sign bit of the second operand.
- Results return through per-requester FIFOs sized by credit, because `fadd` itself cannot stall.

Parameters:
- DEPTH, 4, per-requester result FIFO entries; also the credit limit (power of 2, ≥2).
- LAT, 2, `fadd` latency in cycles (fixed by the instantiated `fadd`; must not be changed independently).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 operation valid
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_x1  in  32  operand a (IEEE single)
- req0_x2  in  32  operand b
- req0_sub  in  1  1: a−b, 0: a+b
- res0_valid  out  1  requester 0 result available
- res0_ready  in  1  requester 0 consumes result
- res0_y  out  32  result
- req1_valid, req1_ready, req1_x1, req1_x2, req1_sub, res1_valid, res1_ready, res1_y: same as requester 0, for requester 1.

Behaviour:
- Clock/reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- `fadd` instance: `x1` = granted x1; `x2` = {granted x2[31]^sub, x2[30:0]}. The result `y` is valid LAT cycles after the operands are presented.
- Credits: cnt_i = in-flight ops tagged i + occupancy of FIFO i, range 0..DEPTH. Requester i is eligible when cnt_i < DEPTH.
- Arbitration:
  - req_i_ready = req_i_valid & eligible_i & granted_i. Ready may depend on valid; a requester must not make valid depend on ready.
  - Single eligible valid requester: it is granted.
  - Both eligible and valid: the grant goes to prio (1-bit pointer, reset 0). After any grant, prio = the other requester.
  - No grant in a cycle: the `fadd` inputs carry don't-care data and a bubble tag.
- Tag pipe: LAT-deep shift register of {valid, id}, reset all invalid. Handshake in cycle t pushes `fadd` y into FIFO[id] at the end of cycle t+LAT.
- Result visibility: res_i_valid is high from cycle t+LAT+1, i.e. 3 cycles after the accepting handshake.
- FIFO i:
  - Registered, first-word-fall-through: res_i_y = head entry.
  - res_i_valid = not empty.
  - Pop on res_i_valid & res_i_ready.
  - Push and pop in the same cycle: both happen, occupancy unchanged; this is legal when full.
  - Overflow is impossible by credit construction; the bench asserts this.
- Credit update each cycle: cnt_i += grant_i − pop_i. Simultaneous grant and pop leaves it unchanged.
  - Credit is freed on pop, not on pipe exit.
  - The ready decision uses the cnt_i registered at the start of the cycle, so a pop in cycle c enables a grant in cycle c+1.
- Ordering: results per requester return strictly in acceptance order. No ordering between requesters.
- Reset:
  - Effect of rst=1 at an edge:
    - Tag pipe invalid.
    - FIFOs empty, cnt=0, prio=0.
    - req*_ready=0 and res*_valid=0 while rst is high.
  - In-flight `fadd` results are discarded. The `fadd` internals are not reset; their outputs are ignored because all tags are invalid.
  - Out of reset, the first grant can happen in the first cycle with rst=0.
- Arithmetic: results are bit-identical to `fadd(x1, x2')`, including its zero-operand bypass (e2==0 ⇒ y=x1; e1==0 ⇒ y=x2'). No additional rounding or NaN handling.

Test Plan:
- Basic add: req0 1.0+2.0 (x1=0x3F800000, x2=0x40000000, sub=0), handshake in cycle 0 → res0_valid in cycle 3, res0_y=0x40400000; res1_valid stays 0.
- Subtract: req1 0x40400000 − 0x3F800000 (sub=1) → res1_y=0x40000000 three cycles after acceptance.
- Contention: both valid every cycle, res*_ready=1 → grants alternate 0,1,0,1 starting with 0 after reset. Every cycle has one grant; each side's results stay in order (feed x1=i, x2=0x3F000000 with 0x3FC00000 → 0x40000000 check).
- Back-pressure: DEPTH=4, res0_ready=0, both always valid → req0_ready handshakes exactly 4 times, then stays 0, while req1 is granted every cycle. Raising res0_ready for one cycle → req0 regains one grant the next cycle.
- Full-FIFO push+pop: FIFO0 full with one more in flight impossible. Check cnt0=DEPTH with a pop and grant in the same cycle → occupancy constant, no overflow, data order preserved.
- Reset mid-flight: accept 2 ops on req0, assert rst the next cycle → no res0_valid ever produced for them, cnt=0. A new op after reset returns only its own result.
